scan_chain_programmer: RTL and testbench

Host-side master for the processor's serial scan chain. Streams a host byte image into the chain (LOAD), or non-destructively reads it back by recirculating (DUMP). In both modes it returns every bit that leaves the chain as bytes. It sits between a byte-wide host port and the accumulator microcontroller's `scan_enable`/`scan_in`/`scan_out` pins, and holds `proc_en` low while the chain is being shifted.

---
 rtl/scan_chain_programmer.sv | 137 +++++++++++++
 tb/tb_scan_chain_programmer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_programmer.sv
// Host-side scan-chain master: LOAD streams a byte image into the chain, DUMP recirculates it.
// Both modes return every bit leaving the chain as LSB-first bytes, zero-padded at the tail.
module scan_chain_programmer #(
    parameter int unsigned CHAIN_LEN = 280
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dump,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    input  logic       proc_en_req,
    output logic       proc_en,
    output logic       scan_enable,
    output logic       scan_data_out,
    input  logic       scan_data_in
);

    localparam int unsigned NBYTES = (CHAIN_LEN + 7) / 8;
    // Wide enough for CHAIN_LEN and never narrower than the 4-bit per-byte counters.
    localparam int unsigned BlW    = $clog2(NBYTES * 8 + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StShift, StEmit, StDone} state_t;

    state_t           state;
    logic             mode_dump;
    logic [BlW-1:0]   bits_left;
    logic [7:0]       tx;
    logic [7:0]       rx;
    logic [7:0]       rx_next;
    logic [7:0]       byte_mask;
    logic [3:0]       bit_cnt;
    logic [3:0]       nb;

    function automatic logic [3:0] chunk(input logic [BlW-1:0] left);
        return (left >= BlW'(8)) ? 4'd8 : left[3:0];
    endfunction

    always_comb begin
        rx_next                = rx;
        rx_next[bit_cnt[2:0]]  = scan_data_in;
        byte_mask              = 8'hFF >> (4'd8 - nb);
    end

    // In DUMP the chain output is fed straight back so exactly CHAIN_LEN shifts restore it.
    assign scan_data_out = (state == StShift) ? (mode_dump ? scan_data_in : tx[0]) : 1'b0;
    assign proc_en       = proc_en_req & (state == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            mode_dump   <= 1'b0;
            bits_left   <= '0;
            tx          <= '0;
            rx          <= '0;
            bit_cnt     <= '0;
            nb          <= '0;
            out_data    <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            scan_enable <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        mode_dump <= dump;
                        bits_left <= BlW'(CHAIN_LEN);
                        busy      <= 1'b1;
                        if (dump) begin
                            nb          <= chunk(BlW'(CHAIN_LEN));
                            bit_cnt     <= '0;
                            scan_enable <= 1'b1;
                            state       <= StShift;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (in_valid) begin
                        tx          <= in_data;
                        in_ready    <= 1'b0;
                        nb          <= chunk(bits_left);
                        bit_cnt     <= '0;
                        scan_enable <= 1'b1;
                        state       <= StShift;
                    end
                end
                StShift: begin
                    rx      <= rx_next;
                    tx      <= {1'b0, tx[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == nb - 4'd1) begin
                        scan_enable <= 1'b0;
                        out_valid   <= 1'b1;
                        out_data    <= rx_next & byte_mask;
                        bits_left   <= bits_left - BlW'(nb);
                        state       <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (bits_left == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else if (mode_dump) begin
                            nb          <= chunk(bits_left);
                            bit_cnt     <= '0;
                            scan_enable <= 1'b1;
                            state       <= StShift;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_programmer.sv
// Bench for scan_chain_programmer with a 12-bit behavioural scan chain attached to its pins.
module tb_scan_chain_programmer;

    localparam int unsigned L  = 12;
    localparam int unsigned NB = (L + 7) / 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dump;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       proc_en_req;
    logic       proc_en;
    logic       scan_enable;
    logic       scan_data_out;
    logic       scan_data_in;

    scan_chain_programmer #(.CHAIN_LEN(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dump          (dump),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .proc_en_req   (proc_en_req),
        .proc_en       (proc_en),
        .scan_enable   (scan_enable),
        .scan_data_out (scan_data_out),
        .scan_data_in  (scan_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: bit 0 sits at scan_out, scan_in enters at bit L-1.
    logic [L-1:0] chain;
    logic         preload_req;
    logic [L-1:0] preload_val;
    logic         mode_dump_tb;
    int           se_cnt;
    int           done_cnt;
    int           mirror_bad;
    logic         sdo_hist [0:4095];

    assign scan_data_in = chain[0];

    always @(posedge clk) begin
        if (preload_req) chain <= preload_val;
        else if (scan_enable) chain <= {scan_data_out, chain[L-1:1]};
        if (scan_enable) begin
            se_cnt <= se_cnt + 1;
            if (se_cnt < 4096) sdo_hist[se_cnt] <= scan_data_out;
            if (mode_dump_tb && (scan_data_out !== scan_data_in)) mirror_bad <= mirror_bad + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input bit dmp, input logic [8*NB-1:0] img, input int in_stall,
                            input int out_stall, input bit poke, output logic [8*NB-1:0] rd);
        int         base;
        int         dbase;
        int         mbase;
        int         n;
        logic [7:0] held;
        bit         stall_ok;
        rd           = '0;
        base         = se_cnt;
        dbase        = done_cnt;
        mbase        = mirror_bad;
        mode_dump_tb = dmp;
        @(negedge clk);
        start = 1'b1;
        dump  = dmp;
        @(negedge clk);
        start = 1'b0;
        dump  = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("proc_en_frozen", 32'(proc_en), 0);
        for (int i = 0; i < NB; i++) begin
            if (!dmp) begin
                check("in_ready", 32'(in_ready), 1);
                stall_ok = 1'b1;
                for (int s = 0; s < in_stall; s++) begin
                    start = poke && (s == 0);
                    dump  = poke && (s == 0);
                    @(negedge clk);
                    if (scan_enable !== 1'b0 || in_ready !== 1'b1 || proc_en !== 1'b0)
                        stall_ok = 1'b0;
                end
                start = 1'b0;
                dump  = 1'b0;
                if (in_stall > 0) check("in_stall_quiet", 32'(stall_ok), 1);
                in_valid = 1'b1;
                in_data  = img[8*i +: 8];
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            n = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("out_valid_seen", 32'(out_valid), 1);
            held     = out_data;
            stall_ok = 1'b1;
            for (int s = 0; s < out_stall; s++) begin
                @(negedge clk);
                if (scan_enable !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
                    stall_ok = 1'b0;
            end
            if (out_stall > 0) check("out_stall_hold", 32'(stall_ok), 1);
            rd[8*i +: 8] = held;
            out_ready    = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("done_pulse", 32'(done), 1);
        check("busy_in_done", 32'(busy), 0);
        check("proc_en_in_done", 32'(proc_en), 0);
        @(negedge clk);
        check("done_single", 32'(done), 0);
        check("proc_en_after_done", 32'(proc_en), 1);
        check("shift_count", 32'(se_cnt - base), L);
        check("done_count", 32'(done_cnt - dbase), 1);
        if (dmp) check("dump_mirror", 32'(mirror_bad - mbase), 0);
        mode_dump_tb = 1'b0;
    endtask

    typedef struct {
        bit             dmp;
        logic [8*NB-1:0] img;
        logic [8*NB-1:0] exp_rd;
        logic [L-1:0]    exp_chain;
    } vec_t;

    vec_t             tbl [5];
    logic [8*NB-1:0]  rd;
    logic [L-1:0]     sdo;
    logic [L-1:0]     chain_ref;
    int               base;
    int               dcnt0;
    bit               quiet;
    bit               rdmp;
    logic [8*NB-1:0]  rimg;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h03A5, 16'h0FFF, 12'h3A5};
        tbl[1] = '{1'b1, 16'h0000, 16'h03A5, 12'h3A5};
        tbl[2] = '{1'b0, 16'hFC5A, 16'h03A5, 12'hC5A};
        tbl[3] = '{1'b1, 16'h0000, 16'h0C5A, 12'hC5A};
        tbl[4] = '{1'b0, 16'h03A5, 16'h0C5A, 12'h3A5};

        rst          = 1'b1;
        start        = 1'b0;
        dump         = 1'b0;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        proc_en_req  = 1'b1;
        preload_req  = 1'b0;
        preload_val  = '0;
        mode_dump_tb = 1'b0;
        checks       = 0;
        errors       = 0;
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_scan_enable", 32'(scan_enable), 0);
        check("rst_scan_data_out", 32'(scan_data_out), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_proc_en", 32'(proc_en), 1);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        base  = se_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scan_enable !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("idle_quiet", 32'(quiet), 1);
        check("idle_no_shift", 32'(se_cnt - base), 0);

        preload_val = 12'hFFF;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;

        for (int v = 0; v < 5; v++) begin
            base = se_cnt;
            run_xfer(tbl[v].dmp, tbl[v].img, 0, 0, 1'b0, rd);
            check("tbl_readback", 32'(rd), 32'(tbl[v].exp_rd));
            check("tbl_chain", 32'(chain), 32'(tbl[v].exp_chain));
            if (!tbl[v].dmp) begin
                for (int k = 0; k < L; k++) sdo[k] = sdo_hist[base + k];
                check("tbl_sdo_seq", 32'(sdo), 32'(tbl[v].img[L-1:0]));
            end
        end

        // Same LOAD as the first table row, now with stalls on both sides.
        preload_val = 12'hFFF;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        run_xfer(1'b0, 16'h03A5, 5, 3, 1'b0, rd);
        check("bp_load_readback", 32'(rd), 32'h0FFF);
        check("bp_load_chain", 32'(chain), 32'h3A5);
        run_xfer(1'b1, 16'h0000, 0, 3, 1'b0, rd);
        check("bp_dump_readback", 32'(rd), 32'h03A5);
        check("bp_dump_chain", 32'(chain), 32'h3A5);

        // A DUMP start pulsed mid-LOAD must be ignored.
        run_xfer(1'b0, 16'h0C5A, 2, 0, 1'b1, rd);
        check("poke_readback", 32'(rd), 32'h03A5);
        check("poke_chain", 32'(chain), 32'hC5A);

        // Reset partway through the first byte's shift.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        dcnt0    = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_scan_enable", 32'(scan_enable), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - dcnt0), 0);
        run_xfer(1'b0, 16'h0C5A, 0, 0, 1'b0, rd);
        check("midrst_reload_chain", 32'(chain), 32'hC5A);

        // Random transfers against a whole-image reference of the chain.
        chain_ref = 12'hC5A;
        for (int t = 0; t < 30; t++) begin
            rdmp = 1'($urandom_range(0, 1));
            rimg = 16'($urandom);
            run_xfer(rdmp, rimg, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, rd);
            check("rnd_readback", 32'(rd), 32'(chain_ref));
            if (!rdmp) chain_ref = rimg[L-1:0];
            check("rnd_chain", 32'(chain), 32'(chain_ref));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
